// File: rtl/vga_frame_sequencer_pkg.sv
// Shared VGA timing defaults, coordinate type and scheduler state encoding
// for the frame sequencer.
package vga_frame_sequencer_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // 640x480@60Hz with a 25 MHz pixel rate
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic {
        SCHED_IDLE = 1'b0,
        SCHED_REQ  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/vga_frame_sequencer_if.sv
// Video timing outputs plus the generation req/ack handshake towards the
// cell-update engine.
interface vga_frame_sequencer_if;
    import vga_frame_sequencer_pkg::*;

    logic         pix_ce;
    logic         hsync;
    logic         vsync;
    logic         video_on;
    coord_t       pix_x;
    coord_t       pix_y;
    logic         frame_start;
    // gen_req rises when a generation is due and stays high until the engine
    // returns gen_ack=1; gen_req drops the cycle after ack is sampled, and an
    // ack while gen_req=0 has no effect.
    logic         gen_req;
    logic         gen_ack;
    logic         gen_overrun;
    sched_state_e sched_state;

    modport master (
        output pix_ce, hsync, vsync, video_on, pix_x, pix_y, frame_start,
        output gen_req, gen_overrun, sched_state,
        input  gen_ack
    );

    modport slave (
        input  pix_ce, hsync, vsync, video_on, pix_x, pix_y, frame_start,
        input  gen_req, gen_overrun, sched_state,
        output gen_ack
    );

endinterface

// File: rtl/vga_frame_sequencer_pix_ce_gen.sv
// Pixel clock-enable divider: one pix_ce pulse every CLK_DIV system clocks
// while en is high; the count freezes while en is low.
module vga_frame_sequencer_pix_ce_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk_100M,
    input  logic Rst_n,
    input  logic en,
    output logic pix_ce
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    assign pix_ce = en && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_frame_sequencer.sv
// VGA raster timing generator with a vertical-blank scheduler that requests
// Game-of-Life generation updates over a req/ack handshake.
module vga_frame_sequencer
    import vga_frame_sequencer_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int GEN_FRAMES = 30
) (
    input  logic                  Clk_100M,
    input  logic                  Rst_n,
    input  logic                  en,
    input  logic                  run,
    input  logic                  step,
    vga_frame_sequencer_if.master bus
);

    localparam int     H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT   = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT   = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_BEG  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [7:0] GEN_LAST = 8'(GEN_FRAMES - 1);

    logic         pix_ce;
    coord_t       pix_x, pix_y, nx, ny;
    logic         hsync, vsync, video_on, frame_start;
    logic         vblank_start, run_trig, trigger;
    logic [7:0]   frame_cnt;
    logic         step_pending;
    logic         gen_req, gen_overrun;
    sched_state_e state;

    vga_frame_sequencer_pix_ce_gen #(.CLK_DIV(CLK_DIV)) u_pix_ce_gen (
        .Clk_100M (Clk_100M),
        .Rst_n    (Rst_n),
        .en       (en),
        .pix_ce   (pix_ce)
    );

    always_comb begin
        nx = (pix_x == H_LAST) ? '0 : pix_x + coord_t'(1);
        ny = pix_y;
        if (pix_x == H_LAST) begin
            ny = (pix_y == V_LAST) ? '0 : pix_y + coord_t'(1);
        end
    end

    assign vblank_start = pix_ce && (nx == '0) && (ny == V_ACT);
    assign run_trig     = vblank_start && run && (frame_cnt == GEN_LAST);
    assign trigger      = run_trig || (vblank_start && step_pending);

    // Decode from the next counts so sync/video land on the same edge as pix_x/pix_y.
    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            pix_x       <= H_LAST;
            pix_y       <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && (nx == '0) && (ny == '0);
            if (pix_ce) begin
                pix_x    <= nx;
                pix_y    <= ny;
                hsync    <= ((nx >= HS_BEG) && (nx <= HS_END)) ? SYNC_POL : ~SYNC_POL;
                vsync    <= ((ny >= VS_BEG) && (ny <= VS_END)) ? SYNC_POL : ~SYNC_POL;
                video_on <= (nx < H_ACT) && (ny < V_ACT);
            end
        end
    end

    always_ff @(posedge Clk_100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= SCHED_IDLE;
            gen_req      <= 1'b0;
            gen_overrun  <= 1'b0;
            frame_cnt    <= '0;
            step_pending <= 1'b0;
        end else begin
            if (step) begin
                step_pending <= 1'b1;
            end else if (vblank_start) begin
                step_pending <= 1'b0;
            end

            if (!run) begin
                frame_cnt <= '0;
            end else if (vblank_start) begin
                frame_cnt <= (frame_cnt == GEN_LAST) ? '0 : frame_cnt + 8'd1;
            end

            case (state)
                SCHED_IDLE: begin
                    if (trigger) begin
                        state   <= SCHED_REQ;
                        gen_req <= 1'b1;
                    end
                end
                SCHED_REQ: begin
                    // An ack coinciding with a new trigger hands over to the new request.
                    if (trigger && !bus.gen_ack) begin
                        gen_overrun <= 1'b1;
                    end
                    if (bus.gen_ack && !trigger) begin
                        state   <= SCHED_IDLE;
                        gen_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= SCHED_IDLE;
                    gen_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ce      = pix_ce;
    assign bus.hsync       = hsync;
    assign bus.vsync       = vsync;
    assign bus.video_on    = video_on;
    assign bus.pix_x       = pix_x;
    assign bus.pix_y       = pix_y;
    assign bus.frame_start = frame_start;
    assign bus.gen_req     = gen_req;
    assign bus.gen_overrun = gen_overrun;
    assign bus.sched_state = state;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer on a reduced 16x12 raster
// (CLK_DIV=4, GEN_FRAMES=2) so several frames fit in a short run.
module tb_vga_frame_sequencer;

    logic Clk_100M;
    logic Rst_n;
    logic en;
    logic run;
    logic step;

    int n_tests;
    int n_fail;
    int edges;

    vga_frame_sequencer_if bus();

    vga_frame_sequencer #(
        .CLK_DIV    (4),
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (3),
        .V_ACTIVE   (6),
        .V_FP       (2),
        .V_SYNC     (2),
        .V_BP       (2),
        .SYNC_POL   (1'b0),
        .GEN_FRAMES (2)
    ) dut (
        .Clk_100M (Clk_100M),
        .Rst_n    (Rst_n),
        .en       (en),
        .run      (run),
        .step     (step),
        .bus      (bus.master)
    );

    // ---------------- clock ----------------
    initial Clk_100M = 1'b0;
    always #5 Clk_100M = ~Clk_100M;

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edges, act, exp);
        end
    endtask

    // Advance to just after the given posedge count (counted from reset release).
    task automatic go_to_edge(input int target);
        while (edges < target) begin
            @(posedge Clk_100M);
            edges++;
        end
        #1;
    endtask

    // One pixel every 4 clocks; pixel n (n=1 is (0,0)) appears after edge 4n.
    typedef struct {
        int n;
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit fs;
    } vec_t;

    vec_t tbl[17];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edges   = 0;

        tbl[0]  = '{8,   7,  0,  1, 1, 1, 0};
        tbl[1]  = '{9,   8,  0,  1, 1, 0, 0};
        tbl[2]  = '{10,  9,  0,  1, 1, 0, 0};
        tbl[3]  = '{11,  10, 0,  0, 1, 0, 0};
        tbl[4]  = '{13,  12, 0,  0, 1, 0, 0};
        tbl[5]  = '{14,  13, 0,  1, 1, 0, 0};
        tbl[6]  = '{16,  15, 0,  1, 1, 0, 0};
        tbl[7]  = '{17,  0,  1,  1, 1, 1, 0};
        tbl[8]  = '{96,  15, 5,  1, 1, 0, 0};
        tbl[9]  = '{97,  0,  6,  1, 1, 0, 0};
        tbl[10] = '{128, 15, 7,  1, 1, 0, 0};
        tbl[11] = '{129, 0,  8,  1, 0, 0, 0};
        tbl[12] = '{140, 11, 8,  0, 0, 0, 0};
        tbl[13] = '{145, 0,  9,  1, 0, 0, 0};
        tbl[14] = '{161, 0,  10, 1, 1, 0, 0};
        tbl[15] = '{192, 15, 11, 1, 1, 0, 0};
        tbl[16] = '{193, 0,  0,  1, 1, 1, 1};

        // ---------------- reset ----------------
        Rst_n       = 1'b0;
        en          = 1'b0;
        run         = 1'b0;
        step        = 1'b0;
        bus.gen_ack = 1'b0;
        repeat (3) @(posedge Clk_100M);
        #1;
        check("rst_pix_ce",      bus.pix_ce,      0);
        check("rst_pix_x",       bus.pix_x,       15);
        check("rst_pix_y",       bus.pix_y,       11);
        check("rst_hsync",       bus.hsync,       1);
        check("rst_vsync",       bus.vsync,       1);
        check("rst_video_on",    bus.video_on,    0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_gen_req",     bus.gen_req,     0);
        check("rst_gen_overrun", bus.gen_overrun, 0);

        @(negedge Clk_100M);
        Rst_n = 1'b1;
        en    = 1'b1;

        // ---------------- divider and first pixel ----------------
        for (int e = 1; e <= 8; e++) begin
            go_to_edge(e);
            check("pix_ce_phase", bus.pix_ce, (e % 4 == 3) ? 1 : 0);
            check("frame_start_first", bus.frame_start, (e == 4) ? 1 : 0);
            if (e == 3) check("pix_x_before_first", bus.pix_x, 15);
            if (e == 4) begin
                check("first_pix_x",    bus.pix_x,    0);
                check("first_pix_y",    bus.pix_y,    0);
                check("first_video_on", bus.video_on, 1);
            end
        end

        // ---------------- raster decode table ----------------
        for (int i = 0; i < 17; i++) begin
            go_to_edge(4 * tbl[i].n);
            check("tbl_pix_x",       bus.pix_x,       tbl[i].x);
            check("tbl_pix_y",       bus.pix_y,       tbl[i].y);
            check("tbl_hsync",       bus.hsync,       tbl[i].hs);
            check("tbl_vsync",       bus.vsync,       tbl[i].vs);
            check("tbl_video_on",    bus.video_on,    tbl[i].vo);
            check("tbl_frame_start", bus.frame_start, tbl[i].fs);
        end
        go_to_edge(4 * 193 + 1);
        check("frame_start_one_cycle", bus.frame_start, 0);

        // ---------------- run mode, GEN_FRAMES=2 ----------------
        run = 1'b1;
        go_to_edge(1157);
        check("run_no_req_first_vblank", bus.gen_req, 0);
        go_to_edge(1923);
        check("run_req_pre", bus.gen_req, 0);
        go_to_edge(1924);
        check("run_req_rise", bus.gen_req, 1);
        go_to_edge(1929);
        bus.gen_ack = 1'b1;
        check("run_req_held", bus.gen_req, 1);
        go_to_edge(1930);
        bus.gen_ack = 1'b0;
        check("run_req_drop", bus.gen_req, 0);
        go_to_edge(3459);
        check("run_req2_pre", bus.gen_req, 0);
        go_to_edge(3460);
        check("run_req2_rise", bus.gen_req, 1);
        go_to_edge(3465);
        bus.gen_ack = 1'b1;
        go_to_edge(3466);
        bus.gen_ack = 1'b0;
        check("run_req2_drop", bus.gen_req, 0);
        check("run_no_overrun", bus.gen_overrun, 0);
        go_to_edge(3470);
        run = 1'b0;

        // ---------------- step, ack withheld, overrun ----------------
        go_to_edge(3480);
        step = 1'b1;
        go_to_edge(3481);
        step = 1'b0;
        go_to_edge(4227);
        check("step_req_pre", bus.gen_req, 0);
        go_to_edge(4228);
        check("step_req_rise", bus.gen_req, 1);
        run = 1'b1;
        go_to_edge(5763);
        check("ovr_pre", bus.gen_overrun, 0);
        check("ovr_req_pre", bus.gen_req, 1);
        go_to_edge(5764);
        check("ovr_set", bus.gen_overrun, 1);
        check("ovr_req_single", bus.gen_req, 1);
        go_to_edge(5770);
        bus.gen_ack = 1'b1;
        go_to_edge(5771);
        bus.gen_ack = 1'b0;
        check("ovr_req_drop", bus.gen_req, 0);
        check("ovr_sticky", bus.gen_overrun, 1);

        // ---------------- ack coincident with a new trigger ----------------
        go_to_edge(5780);
        step = 1'b1;
        go_to_edge(5781);
        step = 1'b0;
        go_to_edge(6531);
        check("step2_req_pre", bus.gen_req, 0);
        go_to_edge(6532);
        check("step2_req_rise", bus.gen_req, 1);
        go_to_edge(7299);
        bus.gen_ack = 1'b1;
        go_to_edge(7300);
        bus.gen_ack = 1'b0;
        check("ack_trig_req_kept", bus.gen_req, 1);
        go_to_edge(7301);
        check("ack_trig_req_after", bus.gen_req, 1);
        go_to_edge(7305);
        bus.gen_ack = 1'b1;
        go_to_edge(7306);
        bus.gen_ack = 1'b0;
        check("ack_trig_req_drop", bus.gen_req, 0);
        go_to_edge(7310);
        run = 1'b0;

        // ---------------- en=0 freeze mid-line ----------------
        go_to_edge(7401);
        check("pre_freeze_x", bus.pix_x, 9);
        check("pre_freeze_y", bus.pix_y, 7);
        en = 1'b0;
        for (int e = 7402; e <= 7501; e++) begin
            go_to_edge(e);
            check("freeze_x",      bus.pix_x,  9);
            check("freeze_y",      bus.pix_y,  7);
            check("freeze_pix_ce", bus.pix_ce, 0);
            check("freeze_hsync",  bus.hsync,  1);
        end
        en = 1'b1;
        go_to_edge(7503);
        check("resume_pix_ce", bus.pix_ce, 1);
        check("resume_x_hold", bus.pix_x, 9);
        go_to_edge(7504);
        check("resume_x", bus.pix_x, 10);
        check("resume_hsync", bus.hsync, 0);

        // ---------------- async reset with a pending request ----------------
        go_to_edge(7510);
        step = 1'b1;
        go_to_edge(7511);
        step = 1'b0;
        go_to_edge(8167);
        check("rst_step_req_pre", bus.gen_req, 0);
        go_to_edge(8168);
        check("rst_step_req_rise", bus.gen_req, 1);
        go_to_edge(8180);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async_gen_req",     bus.gen_req,     0);
        check("async_gen_overrun", bus.gen_overrun, 0);
        check("async_pix_x",       bus.pix_x,       15);
        check("async_pix_y",       bus.pix_y,       11);
        check("async_hsync",       bus.hsync,       1);
        check("async_vsync",       bus.vsync,       1);
        check("async_video_on",    bus.video_on,    0);
        check("async_pix_ce",      bus.pix_ce,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
